conv_clk_gray_ff_ctrl: RTL and testbench

- Pointer/flag controller for a RAM-based FIFO. Generates RAM write/read enables and addresses, full/half-full/not-empty flags, fill levels and flush strobes.
- Pointers are Gray-coded and pass through a 2-flop crossing pipeline, so flag latency matches the team's dual-clock FIFO wrapper.
- Clocked on a single clock. Sits between the FIFO wrapper's read-ahead logic and the dual-port RAM array.

---
 rtl/conv_clk_gray_ff_ctrl.sv | 151 +++++++++++++++
 tb/tb_conv_clk_gray_ff_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_clk_gray_ff_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_clk_gray_ff_ctrl
// Purpose  : Pointer/flag controller for a RAM-based FIFO. Gray-coded
//            pointers cross between the write and read views through
//            2-flop pipelines, so flag latency matches the dual-clock
//            FIFO wrapper even though everything runs on one clock.
// Options  : GRAYFF_ERRCHK_EN adds fifowrerr/fiforderr misuse outputs.
// Revision : 1.0 - initial release
// ============================================================================
module conv_clk_gray_ff_ctrl #(
  parameter int ADD = 7,    // address width, RAM depth 2**ADD
  parameter int LEN = 128   // full threshold, 1..2**ADD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fifowr,
  input  logic           fiford,
  input  logic           fifoflush,
  output logic           oflushwr,
  output logic           oflushrd,
  output logic           fifofull,
  output logic           half_full,
  output logic           fifonemp,
  output logic [ADD:0]   rdfifolen,
  output logic [ADD:0]   wrfifolen,
  output logic           write,
  output logic [ADD-1:0] wraddr,
  output logic           read,
  output logic [ADD-1:0] rdaddr
`ifdef GRAYFF_ERRCHK_EN
  ,
  output logic           fifowrerr,
  output logic           fiforderr
`endif
);

  localparam logic [ADD:0] FULL_LVL = (ADD+1)'(LEN);
  localparam logic [ADD:0] HALF_LVL = (ADD+1)'(LEN / 2);

  function automatic logic [ADD:0] bin2gray(input logic [ADD:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADD:0] gray2bin(input logic [ADD:0] g);
    logic [ADD:0] b;
    b[ADD] = g[ADD];
    for (int i = ADD - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Pointers carry one extra MSB so full and empty are distinguishable
  logic [ADD:0] wrptr, rdptr;
  logic [ADD:0] wrgray, rdgray;
  logic [ADD:0] wrsync1, wrsync2;   // write pointer seen by read side
  logic [ADD:0] rdsync1, rdsync2;   // read pointer seen by write side
  logic         flushq;
  logic [ADD:0] wrptr_inc, rdptr_inc;

  assign wrptr_inc = wrptr + (ADD+1)'(1);
  assign rdptr_inc = rdptr + (ADD+1)'(1);

  // Registered flush request; drives both flush strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flushq <= 1'b0;
    end else begin
      flushq <= fifoflush;
    end
  end

  // Write pointer, its Gray copy and the read-pointer sync stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr   <= '0;
      wrgray  <= '0;
      rdsync1 <= '0;
      rdsync2 <= '0;
    end else if (flushq) begin
      wrptr   <= '0;
      wrgray  <= '0;
      rdsync1 <= '0;
      rdsync2 <= '0;
    end else begin
      if (write) begin
        wrptr  <= wrptr_inc;
        wrgray <= bin2gray(wrptr_inc);
      end
      rdsync1 <= rdgray;
      rdsync2 <= rdsync1;
    end
  end

  // Read pointer, its Gray copy and the write-pointer sync stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdptr   <= '0;
      rdgray  <= '0;
      wrsync1 <= '0;
      wrsync2 <= '0;
    end else if (flushq) begin
      rdptr   <= '0;
      rdgray  <= '0;
      wrsync1 <= '0;
      wrsync2 <= '0;
    end else begin
      if (read) begin
        rdptr  <= rdptr_inc;
        rdgray <= bin2gray(rdptr_inc);
      end
      wrsync1 <= wrgray;
      wrsync2 <= wrsync1;
    end
  end

  // Levels and flags come only from registers; the synced views lag,
  // which keeps full/empty conservative
  always_comb begin
    wrfifolen = wrptr - gray2bin(rdsync2);
    rdfifolen = gray2bin(wrsync2) - rdptr;
    fifofull  = (wrfifolen >= FULL_LVL);
    half_full = (wrfifolen >= HALF_LVL);
    fifonemp  = (rdfifolen != '0);
  end

  assign oflushwr = flushq;
  assign oflushrd = flushq;
  assign write    = fifowr & ~fifofull & ~oflushwr;
  assign read     = fiford & fifonemp & ~oflushrd;
  assign wraddr   = wrptr[ADD-1:0];
  assign rdaddr   = rdptr[ADD-1:0];

`ifdef GRAYFF_ERRCHK_EN
  assign fifowrerr = fifowr & fifofull & ~rst;
  assign fiforderr = fiford & ~fifonemp & ~rst;

`ifndef SYNTHESIS
  // Log every cycle in which the FIFO is misused
  always @(posedge clk) begin
    if (fifowrerr || fiforderr) begin
      $display("conv_clk_gray_ff_ctrl %m: wrerr=%0b rderr=%0b at %0t",
               fifowrerr, fiforderr, $time);
    end
  end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_clk_gray_ff_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_clk_gray_ff_ctrl
// Purpose  : Directed self-checking bench for conv_clk_gray_ff_ctrl with
//            ADD=3, LEN=8, a cycle model of the pointers and a data
//            scoreboard that tracks RAM contents through the addresses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_clk_gray_ff_ctrl;

  localparam int ADD = 3;
  localparam int LEN = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           fifowr = 1'b0, fiford = 1'b0, fifoflush = 1'b0;
  logic           oflushwr, oflushrd, fifofull, half_full, fifonemp;
  logic [ADD:0]   rdfifolen, wrfifolen;
  logic           write, read;
  logic [ADD-1:0] wraddr, rdaddr;
`ifdef GRAYFF_ERRCHK_EN
  logic           fifowrerr, fiforderr;
`endif

  conv_clk_gray_ff_ctrl #(.ADD(ADD), .LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifowr    (fifowr),
    .fiford    (fiford),
    .fifoflush (fifoflush),
    .oflushwr  (oflushwr),
    .oflushrd  (oflushrd),
    .fifofull  (fifofull),
    .half_full (half_full),
    .fifonemp  (fifonemp),
    .rdfifolen (rdfifolen),
    .wrfifolen (wrfifolen),
    .write     (write),
    .wraddr    (wraddr),
    .read      (read),
    .rdaddr    (rdaddr)
`ifdef GRAYFF_ERRCHK_EN
    ,
    .fifowrerr (fifowrerr),
    .fiforderr (fiforderr)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference pointer model: *_d1/_d2 are the pointer values 1 and 2 cycles ago
  logic [ADD:0] m_wp = '0, m_rp = '0, m_wd1 = '0, m_wd2 = '0, m_rd1 = '0, m_rd2 = '0;
  logic         m_fq = 1'b0;

  // Data scoreboard: bench RAM written through the DUT write address
  logic [7:0] mem [0:(1<<ADD)-1];
  logic [7:0] q[$];
  logic [7:0] wdata = 8'h10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_wp = '0; m_rp = '0; m_wd1 = '0; m_wd2 = '0; m_rd1 = '0; m_rd2 = '0;
    q.delete();
  endtask

  // One clock cycle: drive inputs, check all outputs against the model,
  // update scoreboard, cross the edge, advance the model
  task automatic cyc(input logic wr, input logic rd, input logic fl);
    logic [ADD:0] wl, rl;
    logic         ef, eh, en, ew, er;
    fifowr = wr; fiford = rd; fifoflush = fl;
    #2;
    wl = m_wp - m_rd2;
    rl = m_wd2 - m_rp;
    ef = (wl >= 4'(LEN));
    eh = (wl >= 4'(LEN / 2));
    en = (rl != '0);
    ew = wr & ~ef & ~m_fq;
    er = rd & en & ~m_fq;
    chk("flags",     32'({oflushwr, oflushrd, fifofull, half_full, fifonemp}),
                     32'({m_fq, m_fq, ef, eh, en}));
    chk("wrfifolen", 32'(wrfifolen), 32'(wl));
    chk("rdfifolen", 32'(rdfifolen), 32'(rl));
    chk("enables",   32'({write, read}), 32'({ew, er}));
    chk("addrs",     32'({wraddr, rdaddr}), 32'({m_wp[ADD-1:0], m_rp[ADD-1:0]}));
`ifdef GRAYFF_ERRCHK_EN
    chk("errflags",  32'({fifowrerr, fiforderr}), 32'({wr & ef, rd & ~en}));
`endif
    if (read) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'(1));
      if (q.size() != 0) chk("rd_data", 32'(mem[rdaddr]), 32'(q.pop_front()));
    end
    if (write) begin
      mem[wraddr] = wdata;
      q.push_back(wdata);
      wdata = wdata + 8'd1;
    end
    @(posedge clk);
    if (m_fq) begin
      model_clear();
    end else begin
      m_wd2 = m_wd1; m_wd1 = m_wp; m_wp = m_wp + 4'(ew);
      m_rd2 = m_rd1; m_rd1 = m_rp; m_rp = m_rp + 4'(er);
    end
    m_fq = fl;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({oflushwr, oflushrd, fifofull, half_full, fifonemp,
                            rdfifolen, wrfifolen, write, wraddr, read, rdaddr}), 32'(0));
    rst = 1'b0;

    // Single write, then read it back
    cyc(1, 0, 0);
    chk("single_wrlen_c1", 32'(wrfifolen), 32'(1));
    chk("single_nemp_c1",  32'(fifonemp), 32'(0));
    cyc(0, 0, 0);
    chk("single_nemp_c2",  32'(fifonemp), 32'(0));
    cyc(0, 0, 0);
    chk("single_nemp_c3",  32'({fifonemp, rdfifolen}), 32'({1'b1, 4'd1}));
    cyc(0, 1, 0);
    chk("single_nemp_rd",  32'(fifonemp), 32'(0));
    cyc(0, 0, 0);
    chk("single_wrlen_c5", 32'(wrfifolen), 32'(1));
    cyc(0, 0, 0);
    chk("single_wrlen_c6", 32'(wrfifolen), 32'(0));

    // Eight back-to-back writes, then a rejected ninth
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      if (i == 2) chk("half_at_3", 32'(half_full), 32'(0));
      if (i == 3) chk("half_at_4", 32'(half_full), 32'(1));
    end
    chk("full_at_8", 32'({fifofull, wrfifolen}), 32'({1'b1, 4'd8}));
    cyc(1, 0, 0);
    chk("ninth_ignored", 32'(wrfifolen), 32'(8));

    // Drain while writing continuously; address wraps through 7->0
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 0);
      if (i == 0) chk("full_r1", 32'(fifofull), 32'(1));
      if (i == 1) chk("full_r2", 32'(fifofull), 32'(1));
      if (i == 2) chk("full_r3", 32'(fifofull), 32'(0));
    end
    for (int i = 0; i < 16; i++) cyc(0, 1, 0);
    chk("drained", 32'({fifonemp, wrfifolen, 4'(q.size())}), 32'(0));

    // Flush with five entries queued
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("flush_strobes", 32'({oflushwr, oflushrd}), 32'(3));
    cyc(1, 1, 0);
    chk("after_flush", 32'({wrfifolen, rdfifolen, fifonemp, wraddr, rdaddr}), 32'(0));
    cyc(0, 0, 0);

    // Asynchronous reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("pre_rst_len", 32'(rdfifolen), 32'(3));
    fifowr = 1'b0; fiford = 1'b0; fifoflush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 32'({oflushwr, oflushrd, fifofull, half_full, fifonemp,
                          rdfifolen, wrfifolen, write, wraddr, read, rdaddr}), 32'(0));
    model_clear();
    m_fq = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
